race_sequencer: RTL and testbench

- Race-level controller that drives the lap timer's start, stop and lap_finished controls.
- Runs the pre-race countdown and validates laps with a mid-track checkpoint, so cutting the track does not count a lap.
- Counts laps and ends the race after LAPS valid laps.
- Sits between track sensing (finish line and checkpoint hit detection) and the lap timer; runs in the 65 MHz game-logic domain.

---
 rtl/race_sequencer.sv | 168 ++++++++++++++++
 tb/tb_race_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/race_sequencer.sv
// Race-level controller: pre-race countdown, checkpoint-validated lap counting, lap timer control.
// Optional lap timeout (dnf) is built when RACE_TIMEOUT_EN is defined.
module race_sequencer #(
  parameter int unsigned LAPS              = 3,
  parameter int unsigned COUNTDOWN_SEC     = 3,
  parameter int unsigned TICKS_PER_SEC     = 100,
  parameter int unsigned LAP_TIMEOUT_TICKS = 6000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_req,
  input  logic       abort_req,
  input  logic       finish_line,
  input  logic       checkpoint,
  output logic       timer_start,
  output logic       timer_stop,
  output logic       lap_finished,
  output logic [3:0] lap_count,
  output logic [3:0] countdown,
  output logic [1:0] race_state,
  output logic       race_over,
  output logic       dnf
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RACING    = 2'd2,
    S_FINISHED  = 2'd3
  } state_e;

  state_e        state_q;
  logic [TW-1:0] tick_cnt_q;
  logic          armed_q;
  logic          fin_q;
  logic          cp_q;

  logic fin_rise;
  logic cp_rise;
  logic lap_valid;
  logic last_lap;

  assign fin_rise   = finish_line & ~fin_q;
  assign cp_rise    = checkpoint & ~cp_q;
  // A lap is judged on the armed value before this cycle's checkpoint rise.
  assign lap_valid  = fin_rise & armed_q;
  assign last_lap   = ((lap_count + 4'd1) == 4'(LAPS));
  assign race_state = state_q;

`ifdef RACE_TIMEOUT_EN
  localparam int unsigned LTW = $clog2(LAP_TIMEOUT_TICKS + 1);
  logic [LTW-1:0] lap_tmr_q;
  logic           timeout;

  assign timeout = tick & (lap_tmr_q == LTW'(LAP_TIMEOUT_TICKS - 1));
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(LAP_TIMEOUT_TICKS);
  assign dnf            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      armed_q      <= 1'b0;
      fin_q        <= 1'b0;
      cp_q         <= 1'b0;
      timer_start  <= 1'b0;
      timer_stop   <= 1'b0;
      lap_finished <= 1'b0;
      lap_count    <= 4'd0;
      countdown    <= 4'd0;
      race_over    <= 1'b0;
`ifdef RACE_TIMEOUT_EN
      lap_tmr_q    <= '0;
      dnf          <= 1'b0;
`endif
    end else begin
      fin_q        <= finish_line;
      cp_q         <= checkpoint;
      timer_start  <= 1'b0;
      timer_stop   <= 1'b0;
      lap_finished <= 1'b0;

      if (abort_req) begin
        // Abort wins over start; only a running timer needs stopping.
        state_q    <= S_IDLE;
        lap_count  <= 4'd0;
        countdown  <= 4'd0;
        armed_q    <= 1'b0;
        tick_cnt_q <= '0;
        race_over  <= 1'b0;
        timer_stop <= (state_q == S_RACING);
`ifdef RACE_TIMEOUT_EN
        dnf        <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE, S_FINISHED: begin
            if (start_req) begin
              state_q    <= S_COUNTDOWN;
              countdown  <= 4'(COUNTDOWN_SEC);
              tick_cnt_q <= '0;
              lap_count  <= 4'd0;
              armed_q    <= 1'b0;
              race_over  <= 1'b0;
`ifdef RACE_TIMEOUT_EN
              dnf        <= 1'b0;
`endif
            end
          end

          S_COUNTDOWN: begin
            if (tick) begin
              if (tick_cnt_q == TW'(TICKS_PER_SEC - 1)) begin
                tick_cnt_q <= '0;
                countdown  <= countdown - 4'd1;
                if (countdown == 4'd1) begin
                  state_q     <= S_RACING;
                  timer_start <= 1'b1;
`ifdef RACE_TIMEOUT_EN
                  lap_tmr_q   <= '0;
`endif
                end
              end else begin
                tick_cnt_q <= tick_cnt_q + TW'(1);
              end
            end
          end

          S_RACING: begin
            armed_q <= cp_rise | (armed_q & ~fin_rise);
            if (lap_valid) begin
              lap_finished <= 1'b1;
              lap_count    <= lap_count + 4'd1;
`ifdef RACE_TIMEOUT_EN
              lap_tmr_q    <= '0;
`endif
              if (last_lap) begin
                timer_stop <= 1'b1;
                race_over  <= 1'b1;
                state_q    <= S_FINISHED;
              end
            end
`ifdef RACE_TIMEOUT_EN
            else if (timeout) begin
              timer_stop <= 1'b1;
              dnf        <= 1'b1;
              race_over  <= 1'b1;
              state_q    <= S_FINISHED;
            end else if (tick) begin
              lap_tmr_q <= lap_tmr_q + LTW'(1);
            end
`endif
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_race_sequencer.sv
// Scoreboard bench for race_sequencer: timer/lap pulse events are queued when stimulus is driven
// and matched as the DUT emits them; state outputs are checked directly.
module tb_race_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start_req;
  logic       abort_req;
  logic       finish_line;
  logic       checkpoint;
  logic       timer_start;
  logic       timer_stop;
  logic       lap_finished;
  logic [3:0] lap_count;
  logic [3:0] countdown;
  logic [1:0] race_state;
  logic       race_over;
  logic       dnf;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] obs_ev;
  logic [6:0] exp_ev;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  race_sequencer #(
    .LAPS              (2),
    .COUNTDOWN_SEC     (3),
    .TICKS_PER_SEC     (4),
    .LAP_TIMEOUT_TICKS (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .start_req    (start_req),
    .abort_req    (abort_req),
    .finish_line  (finish_line),
    .checkpoint   (checkpoint),
    .timer_start  (timer_start),
    .timer_stop   (timer_stop),
    .lap_finished (lap_finished),
    .lap_count    (lap_count),
    .countdown    (countdown),
    .race_state   (race_state),
    .race_over    (race_over),
    .dnf          (dnf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ev(input bit st, input bit sp, input bit lp, input logic [3:0] cnt);
    return {st, sp, lp, cnt};
  endfunction

  // Any pulse on the timer/lap outputs must match the next queued event.
  always @(negedge clk) begin
    if (mon_en && (timer_start || timer_stop || lap_finished)) begin
      obs_ev = {timer_start, timer_stop, lap_finished, lap_count};
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", 32'(obs_ev), 32'd0);
      end else begin
        exp_ev = exp_q.pop_front();
        check_eq("pulse_event", 32'(obs_ev), 32'(exp_ev));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic sense(input bit fin, input bit cp);
    finish_line = fin;
    checkpoint  = cp;
    step(2);
    finish_line = 1'b0;
    checkpoint  = 1'b0;
    step(1);
  endtask

  task automatic start_race();
    start_req = 1'b1;
    step(1);
    start_req = 1'b0;
    check_eq("state_countdown", 32'(race_state), 32'd1);
  endtask

  task automatic run_countdown();
    for (int s = 3; s >= 1; s--) begin
      check_eq("countdown_val", 32'(countdown), 32'(s));
      for (int t = 0; t < 4; t++) begin
        if (s == 1 && t == 3) exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 4'd0));
        do_tick();
      end
    end
    check_eq("state_racing", 32'(race_state), 32'd2);
    check_eq("countdown_zero", 32'(countdown), 32'd0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start_req = 1'b0; abort_req = 1'b0;
    finish_line = 1'b0; checkpoint = 1'b0;
    step(2);
    rst = 1'b0;
    mon_en = 1'b1;
    check_eq("rst_state", 32'(race_state), 32'd0);
    check_eq("rst_outputs", 32'({timer_start, timer_stop, lap_finished, lap_count, countdown, race_over, dnf}), 32'd0);

    // Countdown into the race
    start_race();
    run_countdown();

    // Start-grid crossing does not count
    sense(1'b1, 1'b0);
    check_eq("grid_lapcount", 32'(lap_count), 32'd0);

    // First valid lap
    sense(1'b0, 1'b1);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 4'd1));
    sense(1'b1, 1'b0);
    check_eq("lap1_count", 32'(lap_count), 32'd1);
    check_eq("lap1_state", 32'(race_state), 32'd2);

    // Simultaneous rise while disarmed: no lap, but arms
    sense(1'b1, 1'b1);
    check_eq("simul_count", 32'(lap_count), 32'd1);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 4'd2));
    sense(1'b1, 1'b0);
    check_eq("final_count", 32'(lap_count), 32'd2);
    check_eq("final_state", 32'(race_state), 32'd3);
    check_eq("race_over_set", 32'(race_over), 32'd1);
    check_eq("dnf_clear", 32'(dnf), 32'd0);

    // Restart from FINISHED, one lap, then abort+start together
    start_race();
    check_eq("restart_over", 32'(race_over), 32'd0);
    check_eq("restart_count", 32'(lap_count), 32'd0);
    run_countdown();
    sense(1'b0, 1'b1);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 4'd1));
    sense(1'b1, 1'b0);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 4'd0));
    abort_req = 1'b1;
    start_req = 1'b1;
    step(1);
    abort_req = 1'b0;
    start_req = 1'b0;
    check_eq("abort_state", 32'(race_state), 32'd0);
    check_eq("abort_count", 32'(lap_count), 32'd0);
    step(2);
    check_eq("abort_stays_idle", 32'(race_state), 32'd0);

    // Abort during countdown: no stop pulse
    start_race();
    do_tick();
    abort_req = 1'b1;
    step(1);
    abort_req = 1'b0;
    check_eq("cd_abort_state", 32'(race_state), 32'd0);
    check_eq("cd_abort_countdown", 32'(countdown), 32'd0);

`ifdef RACE_TIMEOUT_EN
    // Lap timeout: 10 ticks with no lap
    start_race();
    run_countdown();
    repeat (9) do_tick();
    check_eq("pre_timeout_state", 32'(race_state), 32'd2);
    check_eq("pre_timeout_dnf", 32'(dnf), 32'd0);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 4'd0));
    do_tick();
    check_eq("timeout_dnf", 32'(dnf), 32'd1);
    check_eq("timeout_state", 32'(race_state), 32'd3);
    check_eq("timeout_over", 32'(race_over), 32'd1);
    start_race();
    check_eq("restart_dnf", 32'(dnf), 32'd0);
    abort_req = 1'b1;
    step(1);
    abort_req = 1'b0;
`endif

    // Reset mid-race: back to reset values, no stop pulse
    start_race();
    run_countdown();
    sense(1'b0, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("midrst_state", 32'(race_state), 32'd0);
    check_eq("midrst_outputs", 32'({timer_start, timer_stop, lap_finished, lap_count, countdown, race_over, dnf}), 32'd0);
    // Armed must have cleared: a finish rise right after reset is no lap
    start_race();
    run_countdown();
    sense(1'b1, 1'b0);
    check_eq("midrst_disarmed", 32'(lap_count), 32'd0);

    step(3);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
